pipeline_ctrl: RTL
==================

# pipeline_ctrl

Central stall/flush sequencer for the five-stage 64-bit RISC-V pipeline. Each cycle it drives the write-enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three conditions in priority order: a data-memory wait, a taken branch, and a load-use hazard. It also tracks multi-cycle memory waits with a timeout that latches a sticky error.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of consecutive MEM_WAIT cycles before the error state is entered. Range 2..65535.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- dmem_req  in  1  MEM stage is issuing a data access this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_write  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX clear of control bits (bubble)
- ex_mem_write  out  1  EX/MEM load enable
- mem_wb_bubble  out  1  forces reg_write=0 and mem_to_reg=0 into MEM/WB
- mem_err  out  1  sticky memory-timeout error

## Operation
- States: RUN, MEM_WAIT, ERROR. Wait counter: 16 bits.
- Freeze pattern: all *_write=0, both flushes=0, mem_wb_bubble=1.
- Default pattern: all *_write=1, flushes=0, mem_wb_bubble=0.
- Outputs are combinational from state and inputs. Priority within a cycle: memory wait > branch > load-use.
- RUN behaviour:
  - dmem_req=1 and dmem_ready=0: freeze pattern; next state MEM_WAIT; counter is set to 1.
  - Otherwise, ex_branch_taken=1: default pattern plus if_id_flush=1 and id_ex_flush=1. pc_write=1 so the redirect loads.
  - Otherwise, load-use: ex_mem_read=1, ex_rd≠0, and ex_rd equals id_rs1 or id_rs2. Outputs: pc_write=0, if_id_write=0, id_ex_flush=1; everything else default.
  - Otherwise: default pattern.
- MEM_WAIT behaviour:
  - dmem_ready=0 and counter < TIMEOUT_CYCLES: freeze pattern; counter increments.
  - dmem_ready=0 and counter = TIMEOUT_CYCLES: freeze pattern; next state ERROR; mem_err is set.
  - dmem_ready=1: release cycle. Branch and load-use are evaluated exactly as in RUN, without the memory check. Next state RUN; counter clears.
  - dmem_req is ignored in this state, because the request is held by the freeze.
- ERROR: freeze pattern permanently; mem_err=1. Only rst exits this state.
- A load-use hazard against x0 never stalls.
- If branch and load-use are both true in the same cycle, the branch wins. The ID instruction is flushed anyway.

## Timing
- Reset values while rst=1: state RUN, counter 0, mem_err 0. Outputs are forced to freeze pattern with mem_wb_bubble=1.
- First cycle after reset deassertion: outputs follow RUN rules.
- Latency: zero-cycle combinational response to hazard inputs. State changes on the rising edge of clk.
- Load-use produces exactly one bubble: the next cycle ex_mem_read has cleared via the ID/EX flush.
- Taken branch costs 2 flushed slots (IF/ID and ID/EX) in one cycle.
- A memory access with dmem_ready arriving N cycles after the request costs N freeze cycles.
- Reset asserted mid-MEM_WAIT or in ERROR: returns immediately (asynchronously) to the reset values.

## Configuration
- PIPE_PERF_CNT_EN defined: adds output stall_cycles[31:0] and output flush_count[31:0].
  - stall_cycles increments for every cycle with pc_write=0 outside reset.
  - flush_count increments for every taken-branch flush.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- PIPE_PERF_CNT_EN undefined: both ports and their counters are absent; no other behaviour changes.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERROR) in a 2-bit encoding;
  - the REG_X0 constant (5'd0);
  - the default TIMEOUT_CYCLES value.
- Sub-module hazard_detect is purely combinational. It takes id_rs1, id_rs2, ex_mem_read and ex_rd, and outputs load_use.

## Test plan
- Load x5 in EX (ex_rd=5, ex_mem_read=1), id_rs2=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1, then default pattern.
- ex_rd=0, ex_mem_read=1, id_rs1=0 -> no stall; default pattern.
- ex_branch_taken=1 together with a load-use match -> if_id_flush=1, id_ex_flush=1, pc_write=1.
- dmem_req=1 with dmem_ready arriving 3 cycles later -> 3 freeze cycles with mem_wb_bubble=1, then release; state returns to RUN.
- TIMEOUT_CYCLES=4, dmem_ready held 0 -> mem_err=1 after 4 wait cycles, freeze held; rst pulse clears mem_err and returns to RUN.
- PIPE_PERF_CNT_EN defined: 2 load-use stalls plus 1 branch -> stall_cycles=2, flush_count=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector: a load in EX feeding a source operand of the ID instruction.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline with data-memory wait timeout.
// Optional performance counters are enabled with PIPE_PERF_CNT_EN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_write,
  output logic        mem_wb_bubble,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        mem_err
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

  state_t      state, next_state;
  logic [15:0] cnt, next_cnt;
  logic        set_err;
  logic        freeze;
  logic        resolve;
  logic        load_use;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (set_err) mem_err <= 1'b1;
    end
  end

  always_comb begin
    next_state    = state;
    next_cnt      = cnt;
    set_err       = 1'b0;
    freeze        = 1'b0;
    resolve       = 1'b0;
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_write  = 1'b1;
    mem_wb_bubble = 1'b0;

    if (rst) begin
      freeze = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            freeze     = 1'b1;
            next_state = MEM_WAIT;
            next_cnt   = 16'd1;
          end else begin
            resolve = 1'b1;
          end
        end
        // dmem_req is not looked at here: the freeze holds the request in MEM.
        MEM_WAIT: begin
          if (!dmem_ready) begin
            freeze = 1'b1;
            if (cnt < TIMEOUT_W) begin
              next_cnt = cnt + 16'd1;
            end else begin
              next_state = ERROR;
              set_err    = 1'b1;
            end
          end else begin
            resolve    = 1'b1;
            next_state = RUN;
            next_cnt   = '0;
          end
        end
        ERROR: freeze = 1'b1;
        default: begin
          freeze     = 1'b1;
          next_state = RUN;
          next_cnt   = '0;
        end
      endcase
    end

    if (freeze) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (resolve && ex_branch_taken) begin
      // Branch beats load-use: the dependent ID instruction is squashed anyway.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (resolve && load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_write && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (pc_write && if_id_flush && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule
